// File: rtl/e_mdu_issue_ctrl.sv
// E-stage issue and interlock control for the multiply/divide unit: start pulse, op gating,
// D-stage stall, shadow busy counter cross-checked against the MDU, and a stall-cycle counter.
module e_mdu_issue_ctrl #(
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        d_mdu_en,
  input  logic        e_valid,
  input  logic        e_mdu_en,
  input  logic [3:0]  e_mdu_op,
  input  logic        e_flush,
  input  logic        mdu_busy,
  output logic        mdu_start,
  output logic [3:0]  mdu_op,
  output logic        stall_d,
  output logic        shadow_busy,
  output logic        err,
  output logic [31:0] stall_cycles
);

  localparam int CW = $clog2(DIV_CYC + 1);

  localparam logic [3:0] OP_MULTU = 4'd1;
  localparam logic [3:0] OP_DIVU  = 4'd3;
  localparam logic [3:0] OP_NONE  = 4'hF;

  logic          live;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
  logic [31:0]   stall_cycles_q, stall_cycles_d;

  // Bubbles and flushed slots must present NONE so no stray mthi/mtlo reaches HI/LO.
  assign live        = e_valid & e_mdu_en & ~e_flush;
  assign mdu_op      = live ? e_mdu_op : OP_NONE;
  assign mdu_start   = live & (e_mdu_op <= OP_DIVU);
  assign shadow_busy = (cnt_q != '0);

  // The start cycle is covered explicitly: the MDU has not registered busy yet.
  assign stall_d = d_mdu_en & (mdu_start | shadow_busy | mdu_busy);

  assign err          = err_q;
  assign stall_cycles = stall_cycles_q;

  // NOTE: combinational blocks use blocking assignments and give every output a default
  // first, so no path leaves a value held and no latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    if (mdu_start && (e_mdu_op <= OP_MULTU)) begin
      cnt_d = CW'(MULT_CYC);
    end else if (mdu_start) begin
      cnt_d = CW'(DIV_CYC);
    end else if (shadow_busy) begin
      cnt_d = cnt_q - CW'(1);
    end

    // Sticky: MDU disagrees with the shadow, or a start slipped past the interlock.
    err_d = err_q | (mdu_busy != shadow_busy) | (mdu_start & shadow_busy);

    stall_cycles_d = stall_cycles_q + 32'(stall_d);
  end

  // NOTE: sequential state uses non-blocking assignments; reset is synchronous and shared
  // with the MDU, so clearing cnt here abandons any in-flight result.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q          <= '0;
      err_q          <= 1'b0;
      stall_cycles_q <= '0;
    end else begin
      cnt_q          <= cnt_d;
      err_q          <= err_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

endmodule

// File: tb/tb_e_mdu_issue_ctrl.sv
// Self-checking bench for e_mdu_issue_ctrl: directed scenarios plus randomized traffic
// compared against a busy-window reference model with a behavioural MDU driving mdu_busy.
module tb_e_mdu_issue_ctrl;

  localparam int MULT_CYC = 5;
  localparam int DIV_CYC  = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        d_mdu_en, e_valid, e_mdu_en, e_flush, mdu_busy;
  logic [3:0]  e_mdu_op;
  logic        mdu_start, stall_d, shadow_busy, err;
  logic [3:0]  mdu_op;
  logic [31:0] stall_cycles;

  int checks = 0;
  int errors = 0;

  // Reference model: a start at cycle s of length n keeps the unit busy in cycles s+1..s+n.
  longint      cyc;
  longint      start_cyc;
  int          busy_len;
  bit          err_m;
  logic [31:0] stall_m;

  e_mdu_issue_ctrl #(.MULT_CYC(MULT_CYC), .DIV_CYC(DIV_CYC)) dut (
    .clk          (clk),
    .reset        (reset),
    .d_mdu_en     (d_mdu_en),
    .e_valid      (e_valid),
    .e_mdu_en     (e_mdu_en),
    .e_mdu_op     (e_mdu_op),
    .e_flush      (e_flush),
    .mdu_busy     (mdu_busy),
    .mdu_start    (mdu_start),
    .mdu_op       (mdu_op),
    .stall_d      (stall_d),
    .shadow_busy  (shadow_busy),
    .err          (err),
    .stall_cycles (stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%h expected=%h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic bit model_busy();
    return (busy_len != 0) && (cyc > start_cyc) && (cyc <= start_cyc + longint'(busy_len));
  endfunction

  function automatic bit unit_busy();
    return model_busy();
  endfunction

  // One clock cycle: drive at negedge, check combinational and registered outputs, then
  // advance the model to the state expected after the following posedge.
  task automatic cycle(input bit rst, input bit d_en, input bit v, input bit en,
                       input logic [3:0] op, input bit fl, input bit inj);
    bit         live, exp_start, exp_sb, exp_stall;
    logic [3:0] exp_op;
    @(negedge clk);
    reset    = rst;
    d_mdu_en = d_en;
    e_valid  = v;
    e_mdu_en = en;
    e_mdu_op = op;
    e_flush  = fl;
    mdu_busy = unit_busy() ^ inj;
    #1;
    live      = v && en && !fl;
    exp_op    = live ? op : 4'hF;
    exp_start = live && (op < 4'd4);
    exp_sb    = model_busy();
    exp_stall = d_en && (exp_start || exp_sb || mdu_busy);
    check("mdu_op",       {28'd0, mdu_op},      {28'd0, exp_op});
    check("mdu_start",    {31'd0, mdu_start},   {31'd0, exp_start});
    check("shadow_busy",  {31'd0, shadow_busy}, {31'd0, exp_sb});
    check("stall_d",      {31'd0, stall_d},     {31'd0, exp_stall});
    check("err",          {31'd0, err},         {31'd0, err_m});
    check("stall_cycles", stall_cycles,         stall_m);
    if (rst) begin
      busy_len = 0;
      err_m    = 1'b0;
      stall_m  = '0;
    end else begin
      if ((mdu_busy != exp_sb) || (exp_start && exp_sb)) err_m = 1'b1;
      if (exp_stall) stall_m = stall_m + 32'd1;
      if (exp_start) begin
        start_cyc = cyc;
        busy_len  = (op < 4'd2) ? MULT_CYC : DIV_CYC;
      end
    end
    cyc++;
  endtask

  task automatic idle(input bit d_en);
    cycle(1'b0, d_en, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
  endtask

  initial begin
    int sb_cnt, st_cnt;
    reset = 1'b1; d_mdu_en = 1'b0; e_valid = 1'b0; e_mdu_en = 1'b0;
    e_mdu_op = 4'd0; e_flush = 1'b0; mdu_busy = 1'b0;
    repeat (2) @(posedge clk);
    cyc = 0; start_cyc = 0; busy_len = 0; err_m = 1'b0; stall_m = '0;

    // Reset state with idle inputs.
    idle(1'b0);
    check("reset_op_none", {28'd0, mdu_op}, 32'h0000_000F);
    check("reset_stall_cnt", stall_cycles, 32'd0);

    // Scenario 1: mult in E with mflo waiting in D.
    do_reset();
    cycle(1'b0, 1'b1, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0);
    repeat (5) idle(1'b1);
    idle(1'b1);
    check("s1_released", {31'd0, stall_d}, 32'd0);
    cycle(1'b0, 1'b0, 1'b1, 1'b1, 4'd5, 1'b0, 1'b0);
    check("s1_mflo_op", {28'd0, mdu_op}, 32'd5);
    check("s1_stall_cnt", stall_cycles, 32'd6);
    check("s1_err", {31'd0, err}, 32'd0);

    // Scenario 2: divu followed by a non-MDU instruction.
    do_reset();
    sb_cnt = 0; st_cnt = 0;
    cycle(1'b0, 1'b0, 1'b1, 1'b1, 4'd3, 1'b0, 1'b0);
    for (int i = 0; i < 13; i++) begin
      idle(1'b0);
      sb_cnt += int'(shadow_busy);
      st_cnt += int'(stall_d);
    end
    check("s2_busy_len", sb_cnt, 32'd10);
    check("s2_no_stall", st_cnt, 32'd0);

    // Scenario 3: bubble holding mthi, then flushed mult.
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 4'd6, 1'b0, 1'b0);
    check("s3_bubble_op", {28'd0, mdu_op}, 32'h0000_000F);
    cycle(1'b0, 1'b1, 1'b1, 1'b1, 4'd0, 1'b1, 1'b0);
    check("s3_flush_start", {31'd0, mdu_start}, 32'd0);
    idle(1'b0);
    check("s3_cnt_zero", {31'd0, shadow_busy}, 32'd0);

    // Scenario 4: MDU reports busy while the shadow counter is idle.
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
    idle(1'b0);
    check("s4_err_set", {31'd0, err}, 32'd1);
    repeat (3) idle(1'b0);
    check("s4_err_sticky", {31'd0, err}, 32'd1);

    // Scenario 5: reset three cycles into a div.
    do_reset();
    cycle(1'b0, 1'b1, 1'b1, 1'b1, 4'd2, 1'b0, 1'b0);
    idle(1'b1);
    idle(1'b1);
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    idle(1'b1);
    check("s5_busy", {31'd0, shadow_busy}, 32'd0);
    check("s5_stall", {31'd0, stall_d}, 32'd0);
    check("s5_err", {31'd0, err}, 32'd0);
    check("s5_stall_cnt", stall_cycles, 32'd0);

    // Scenario 6: stall counter wraps.
    @(posedge clk);
    #1 force dut.stall_cycles_q = 32'hFFFF_FFFF;
    #1 release dut.stall_cycles_q;
    stall_m = 32'hFFFF_FFFF;
    cycle(1'b0, 1'b1, 1'b1, 1'b1, 4'd1, 1'b0, 1'b0);
    idle(1'b0);
    check("s6_wrap", stall_cycles, 32'd0);

    // Randomized traffic; starts mostly respect the interlock, occasionally not.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      bit         rst, d_en, v, en, fl, inj;
      logic [3:0] op;
      rst  = ($urandom_range(0, 149) == 0);
      inj  = ($urandom_range(0, 299) == 0);
      d_en = $urandom_range(0, 1);
      v    = ($urandom_range(0, 3) != 0);
      en   = ($urandom_range(0, 3) != 0);
      fl   = ($urandom_range(0, 7) == 0);
      op   = 4'($urandom_range(0, 15));
      if (model_busy() && (op < 4'd4) && ($urandom_range(0, 19) != 0)) v = 1'b0;
      cycle(rst, d_en, v, en, op, fl, inj);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
